// File: rtl/rr_arb_spill_flushable_pkg.sv
// Shared types for the round-robin arbiter with a flushable spill register.
`timescale 1ns/1ps
package rr_arb_spill_flushable_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rr_spill_state_e;

  // Modulo-n step used by both the priority rotate and the pointer update.
  function automatic int unsigned rr_wrap_idx(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry spill register with synchronous clear and a flush that discards all entries.
`timescale 1ns/1ps
module spill_register_flushable #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic valid_i,
  input  logic flush_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    assign valid_o = valid_i & ~flush_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_spill
    logic a_full_q, a_full_d, b_full_q, b_full_d;
    T     a_data_q, a_data_d, b_data_q, b_data_d;
    logic a_fill, a_drain, b_fill, b_drain;

    // B only takes A's entry when downstream stalls, so B always holds the older beat.
    always_comb begin
      a_fill   = valid_i & ready_o & ~flush_i;
      a_drain  = (a_full_q & ~b_full_q) | flush_i;
      b_fill   = a_drain & ~ready_i & ~flush_i;
      b_drain  = (b_full_q & ready_i) | flush_i;
      a_full_d = a_full_q;
      a_data_d = a_data_q;
      b_full_d = b_full_q;
      b_data_d = b_data_q;
      if (a_fill | a_drain) a_full_d = a_fill;
      if (a_fill)           a_data_d = data_i;
      if (b_fill | b_drain) b_full_d = b_fill;
      if (b_fill)           b_data_d = a_data_q;
      if (clr_i) begin
        a_full_d = 1'b0;
        a_data_d = '0;
        b_full_d = 1'b0;
        b_data_d = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        a_data_q <= '0;
        b_full_q <= 1'b0;
        b_data_q <= '0;
      end else begin
        a_full_q <= a_full_d;
        a_data_q <= a_data_d;
        b_full_q <= b_full_d;
        b_data_q <= b_data_d;
      end
    end

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
  end

endmodule

// File: rtl/rr_arb_spill_flushable.sv
// Round-robin arbiter feeding one flushable spill register, with a RUN/FLUSH sequencer.
`timescale 1ns/1ps
module rr_arb_spill_flushable
  import rr_arb_spill_flushable_pkg::*;
#(
  parameter int unsigned NumInp   = 4,
  parameter type         T        = logic,
  parameter int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [NumInp-1:0]   valid_i,
  output logic [NumInp-1:0]   ready_o,
  input  T     [NumInp-1:0]   data_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [IdxWidth-1:0] idx_o
);

  typedef struct packed {
    T                    data;
    logic [IdxWidth-1:0] idx;
  } spill_t;

  rr_spill_state_e     state_q, state_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d, winner;
  logic                flush_ack_q, flush_ack_d;
  logic                any_valid, arb_en;
  logic                spill_valid, spill_ready, spill_flush;
  int unsigned         cand;
  spill_t              spill_in, spill_out;

  always_comb begin : winner_search
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < NumInp; off++) begin
      cand = rr_wrap_idx(32'(ptr_q), off, NumInp);
      if (!any_valid && valid_i[cand[IdxWidth-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin : control
    state_d     = state_q;
    ptr_d       = ptr_q;
    flush_ack_d = 1'b0;
    // rst_ni gates ready so that asserting reset drops it without waiting for an edge.
    arb_en      = rst_ni & ~clr_i & (state_q == RUN) & ~flush_req_i;
    spill_valid = arb_en & any_valid;
    spill_flush = (state_q == FLUSH);
    ready_o     = '0;
    if (spill_valid) ready_o[winner] = spill_ready;
    case (state_q)
      RUN: begin
        if (flush_req_i) begin
          state_d     = FLUSH;
          flush_ack_d = 1'b1;
        end else if (spill_valid && spill_ready) begin
          ptr_d = IdxWidth'(rr_wrap_idx(32'(winner), 1, NumInp));
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (clr_i) begin
      state_d     = RUN;
      ptr_d       = '0;
      flush_ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      flush_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  assign spill_in.data = data_i[winner];
  assign spill_in.idx  = winner;

  spill_register_flushable #(
    .T      (spill_t),
    .Bypass (1'b0)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .valid_i (spill_valid),
    .flush_i (spill_flush),
    .ready_o (spill_ready),
    .data_i  (spill_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (spill_out)
  );

  assign flush_ack_o = flush_ack_q;
  assign data_o      = spill_out.data;
  assign idx_o       = spill_out.idx;

  a_no_flush_with_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(spill_flush && spill_valid));

endmodule

// File: tb/tb_rr_arb_spill_flushable.sv
// Directed bench for rr_arb_spill_flushable with 4 requesters and byte payloads.
`timescale 1ns/1ps
module tb_rr_arb_spill_flushable;

  localparam int unsigned N = 4;

  logic                clk = 1'b0;
  logic                rst_ni, clr_i, flush_req_i, flush_ack_o, valid_o, ready_i;
  logic [N-1:0]        valid_i, ready_o;
  logic [N-1:0][7:0]   data_i;
  logic [7:0]          data_o;
  logic [1:0]          idx_o;
  int                  vectors = 0;
  int                  miscompares = 0;

  always #5 clk = ~clk;

  rr_arb_spill_flushable #(
    .NumInp (N),
    .T      (logic [7:0])
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .flush_req_i (flush_req_i),
    .flush_ack_o (flush_ack_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .idx_o       (idx_o)
  );

  task automatic test_reset();
    rst_ni = 1'b0; clr_i = 1'b0; flush_req_i = 1'b0; ready_i = 1'b1;
    valid_i = '1; data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (ready_o !== 4'b0000) begin $display("FAIL reset_ready: got %b want 0000", ready_o); miscompares++; end
    vectors++; if (valid_o !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid_o); miscompares++; end
    vectors++; if (flush_ack_o !== 1'b0) begin $display("FAIL reset_ack: got %b want 0", flush_ack_o); miscompares++; end
    vectors++; if (idx_o !== 2'd0) begin $display("FAIL reset_idx: got %0d want 0", idx_o); miscompares++; end
    vectors++; if (data_o !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data_o); miscompares++; end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL rr_first_ready: got %b want 0001", ready_o); miscompares++; end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      exp_idx = 2'(k % 4);
      exp_rdy = 4'(1 << ((k + 1) % 4));
      vectors++; if (valid_o !== 1'b1) begin $display("FAIL rr_valid[%0d]: got %b want 1", k, valid_o); miscompares++; end
      vectors++; if (idx_o !== exp_idx) begin $display("FAIL rr_idx[%0d]: got %0d want %0d", k, idx_o, exp_idx); miscompares++; end
      vectors++; if (data_o !== 8'h10 + 8'(k % 4)) begin $display("FAIL rr_data[%0d]: got %h want %h", k, data_o, 8'h10 + 8'(k % 4)); miscompares++; end
      vectors++; if (ready_o !== exp_rdy) begin $display("FAIL rr_ready[%0d]: got %b want %b", k, ready_o, exp_rdy); miscompares++; end
    end
    valid_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    clr_i = 1'b1; valid_i = '1; ready_i = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0000) begin $display("FAIL clr_ready: got %b want 0000", ready_o); miscompares++; end
    @(negedge clk);
    clr_i = 1'b0; valid_i = 4'b0100; ready_i = 1'b0; data_i[2] = 8'hA0;
    #1;
    vectors++; if (valid_o !== 1'b0) begin $display("FAIL clr_valid: got %b want 0", valid_o); miscompares++; end
    for (int c = 0; c < 5; c++) begin
      if (valid_i[2] && ready_o[2]) accepts++;
      @(negedge clk);
      data_i[2] = 8'hA0 + 8'(accepts);
      #1;
    end
    vectors++; if (accepts !== 2) begin $display("FAIL bp_accepts: got %0d want 2", accepts); miscompares++; end
    vectors++; if (ready_o !== 4'b0000) begin $display("FAIL bp_ready_full: got %b want 0000", ready_o); miscompares++; end
    vectors++; if (valid_o !== 1'b1 || idx_o !== 2'd2 || data_o !== 8'hA0) begin
      $display("FAIL bp_head: got v=%b idx=%0d d=%h want v=1 idx=2 d=a0", valid_o, idx_o, data_o); miscompares++; end
    ready_i = 1'b1; valid_i = '0;
    @(negedge clk); #1;
    vectors++; if (valid_o !== 1'b1 || idx_o !== 2'd2 || data_o !== 8'hA1) begin
      $display("FAIL bp_second: got v=%b idx=%0d d=%h want v=1 idx=2 d=a1", valid_o, idx_o, data_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (valid_o !== 1'b0) begin $display("FAIL bp_empty: got %b want 0", valid_o); miscompares++; end
  endtask

  task automatic test_wrap_skip();
    @(negedge clk);
    clr_i = 1'b1; valid_i = '0; ready_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0; valid_i = 4'b0001; data_i[0] = 8'hC0;
    #1;
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL ws_ptr0: got %b want 0001", ready_o); miscompares++; end
    @(negedge clk);
    valid_i = 4'b1001; data_i[3] = 8'hC3;
    #1;
    vectors++; if (ready_o !== 4'b1000) begin $display("FAIL ws_skip_to3: got %b want 1000", ready_o); miscompares++; end
    vectors++; if (idx_o !== 2'd0 || data_o !== 8'hC0) begin $display("FAIL ws_out0: got idx=%0d d=%h want idx=0 d=c0", idx_o, data_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL ws_wrap_to0: got %b want 0001", ready_o); miscompares++; end
    vectors++; if (idx_o !== 2'd3 || data_o !== 8'hC3) begin $display("FAIL ws_out3: got idx=%0d d=%h want idx=3 d=c3", idx_o, data_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b1000) begin $display("FAIL ws_again3: got %b want 1000", ready_o); miscompares++; end
    @(negedge clk);
    valid_i = '0;
  endtask

  task automatic test_flush();
    // Full buffer, downstream stalled.
    @(negedge clk);
    clr_i = 1'b1; valid_i = '0; ready_i = 1'b0;
    @(negedge clk);
    clr_i = 1'b0; valid_i = '1; data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    #1;
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL fl_fill0: got %b want 0001", ready_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b0010) begin $display("FAIL fl_fill1: got %b want 0010", ready_o); miscompares++; end
    @(negedge clk);
    flush_req_i = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0000 || flush_ack_o !== 1'b0) begin
      $display("FAIL fl_f0: got rdy=%b ack=%b want rdy=0000 ack=0", ready_o, flush_ack_o); miscompares++; end
    vectors++; if (valid_o !== 1'b1 || idx_o !== 2'd0) begin $display("FAIL fl_f0_out: got v=%b idx=%0d want v=1 idx=0", valid_o, idx_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b0000 || flush_ack_o !== 1'b1) begin
      $display("FAIL fl_f1: got rdy=%b ack=%b want rdy=0000 ack=1", ready_o, flush_ack_o); miscompares++; end
    flush_req_i = 1'b0;
    @(negedge clk); #1;
    vectors++; if (flush_ack_o !== 1'b0 || valid_o !== 1'b0) begin
      $display("FAIL fl_f2: got ack=%b v=%b want ack=0 v=0", flush_ack_o, valid_o); miscompares++; end
    vectors++; if (ready_o !== 4'b0100) begin $display("FAIL fl_f2_ptr: got %b want 0100", ready_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (valid_o !== 1'b1 || idx_o !== 2'd2 || data_o !== 8'hD2) begin
      $display("FAIL fl_resume: got v=%b idx=%0d d=%h want v=1 idx=2 d=d2", valid_o, idx_o, data_o); miscompares++; end
    // Streaming with downstream ready; the flush alone must block inputs.
    @(negedge clk);
    clr_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    #1;
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL fl2_start: got %b want 0001", ready_o); miscompares++; end
    @(negedge clk);
    flush_req_i = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0000 || flush_ack_o !== 1'b0) begin
      $display("FAIL fl2_f0: got rdy=%b ack=%b want rdy=0000 ack=0", ready_o, flush_ack_o); miscompares++; end
    vectors++; if (valid_o !== 1'b1 || idx_o !== 2'd0) begin $display("FAIL fl2_f0_out: got v=%b idx=%0d want v=1 idx=0", valid_o, idx_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b0000 || flush_ack_o !== 1'b1) begin
      $display("FAIL fl2_f1: got rdy=%b ack=%b want rdy=0000 ack=1", ready_o, flush_ack_o); miscompares++; end
    flush_req_i = 1'b0;
    @(negedge clk); #1;
    vectors++; if (ready_o !== 4'b0010 || flush_ack_o !== 1'b0 || valid_o !== 1'b0) begin
      $display("FAIL fl2_f2: got rdy=%b ack=%b v=%b want rdy=0010 ack=0 v=0", ready_o, flush_ack_o, valid_o); miscompares++; end
  endtask

  task automatic test_clear_vs_flush();
    @(negedge clk);
    clr_i = 1'b1; ready_i = 1'b0; valid_i = 4'b0010;
    @(negedge clk);
    clr_i = 1'b0;
    #1;
    vectors++; if (ready_o !== 4'b0010) begin $display("FAIL cf_grant1: got %b want 0010", ready_o); miscompares++; end
    @(negedge clk);
    flush_req_i = 1'b1; clr_i = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0000 || valid_o !== 1'b1 || idx_o !== 2'd1) begin
      $display("FAIL cf_f0: got rdy=%b v=%b idx=%0d want rdy=0000 v=1 idx=1", ready_o, valid_o, idx_o); miscompares++; end
    @(negedge clk);
    clr_i = 1'b0; flush_req_i = 1'b0; valid_i = '1;
    #1;
    vectors++; if (flush_ack_o !== 1'b0 || valid_o !== 1'b0) begin
      $display("FAIL cf_after: got ack=%b v=%b want ack=0 v=0", flush_ack_o, valid_o); miscompares++; end
    vectors++; if (ready_o !== 4'b0001) begin $display("FAIL cf_run_ptr0: got %b want 0001", ready_o); miscompares++; end
    @(negedge clk); #1;
    vectors++; if (flush_ack_o !== 1'b0 || valid_o !== 1'b1 || idx_o !== 2'd0) begin
      $display("FAIL cf_next: got ack=%b v=%b idx=%0d want ack=0 v=1 idx=0", flush_ack_o, valid_o, idx_o); miscompares++; end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clr_i = 1'b1; valid_i = '0; ready_i = 1'b0;
    @(negedge clk);
    clr_i = 1'b0; valid_i = 4'b0100; data_i[2] = 8'hE2;
    #1;
    vectors++; if (ready_o !== 4'b0100) begin $display("FAIL ar_grant2: got %b want 0100", ready_o); miscompares++; end
    @(negedge clk);
    valid_i = '0; flush_req_i = 1'b1;
    @(negedge clk); #1;
    vectors++; if (flush_ack_o !== 1'b1 || valid_o !== 1'b1 || idx_o !== 2'd2 || data_o !== 8'hE2) begin
      $display("FAIL ar_pre: got ack=%b v=%b idx=%0d d=%h want ack=1 v=1 idx=2 d=e2", flush_ack_o, valid_o, idx_o, data_o); miscompares++; end
    flush_req_i = 1'b0; valid_i = 4'b0100;
    #2 rst_ni = 1'b0;
    #1;
    vectors++; if (valid_o !== 1'b0 || ready_o !== 4'b0000 || flush_ack_o !== 1'b0 || idx_o !== 2'd0 || data_o !== 8'h00) begin
      $display("FAIL ar_async: got v=%b rdy=%b ack=%b idx=%0d d=%h want all 0", valid_o, ready_o, flush_ack_o, idx_o, data_o); miscompares++; end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    vectors++; if (ready_o !== 4'b0100) begin $display("FAIL ar_release: got %b want 0100", ready_o); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_flush();
    test_clear_vs_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
